// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - ID lookup, EX resolution and status bundle for the branch predictor
interface branch_predictor_if #(
  parameter int IDX_W  = 4,
  parameter int GHR_W  = 4,
  parameter int STAT_W = 32
);
  logic [31:0]       ID_pc;
  logic              ID_is_branch;
  logic              ID_predict_taken;
  logic [IDX_W-1:0]  ID_pred_idx;
  logic              EX_valid;
  logic              EX_is_branch;
  logic [IDX_W-1:0]  EX_pred_idx;
  logic              EX_predict_taken;
  logic              EX_actual_taken;
  logic              EX_mispredict;
  logic [GHR_W-1:0]  ghr;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispredicts;

  modport master (
    output ID_pc, ID_is_branch, EX_valid, EX_is_branch, EX_pred_idx,
           EX_predict_taken, EX_actual_taken,
    input  ID_predict_taken, ID_pred_idx, EX_mispredict, ghr,
           stat_branches, stat_mispredicts
  );

  modport slave (
    input  ID_pc, ID_is_branch, EX_valid, EX_is_branch, EX_pred_idx,
           EX_predict_taken, EX_actual_taken,
    output ID_predict_taken, ID_pred_idx, EX_mispredict, ghr,
           stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - PC-indexed saturating-counter branch predictor with optional gshare hashing
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int GHR_W   = 4,
  parameter int MODE    = 0,
  parameter int STAT_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  branch_predictor_if.slave  bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);

  logic [CNT_W-1:0]  cnt_q [ENTRIES];
  logic [CNT_W-1:0]  cnt_d;
  logic [GHR_W-1:0]  ghr_q, ghr_d;
  logic [STAT_W-1:0] stat_br_q, stat_br_d;
  logic [STAT_W-1:0] stat_mp_q, stat_mp_d;
  logic [IDX_W-1:0]  base_idx, id_idx;
  logic              upd, mispredict;
  logic              unused_pc;

  assign unused_pc = ^{bp.ID_pc[31:IDX_W+2], bp.ID_pc[1:0]};

  assign base_idx = bp.ID_pc[IDX_W+1:2];

  generate
    if (MODE == 1) begin : g_gshare
      assign id_idx = base_idx ^ IDX_W'(ghr_q);
    end else begin : g_bimodal
      assign id_idx = base_idx;
    end
  endgenerate

  // No bypass: lookups always see the registered table and pre-shift history.
  assign bp.ID_pred_idx      = id_idx;
  assign bp.ID_predict_taken = bp.ID_is_branch & cnt_q[id_idx][CNT_W-1];

  assign upd              = bp.EX_valid & bp.EX_is_branch;
  assign mispredict       = upd & (bp.EX_predict_taken != bp.EX_actual_taken);
  assign bp.EX_mispredict = mispredict;

  always_comb begin
    cnt_d = cnt_q[bp.EX_pred_idx];
    if (bp.EX_actual_taken) begin
      if (cnt_d != '1) cnt_d = cnt_d + CNT_W'(1);
    end else begin
      if (cnt_d != '0) cnt_d = cnt_d - CNT_W'(1);
    end
  end

  generate
    if (GHR_W == 1) begin : g_ghr_1
      assign ghr_d = bp.EX_actual_taken;
    end else begin : g_ghr_n
      assign ghr_d = {ghr_q[GHR_W-2:0], bp.EX_actual_taken};
    end
  endgenerate

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (stat_br_q != '1) stat_br_d = stat_br_q + STAT_W'(1);
    if (mispredict && (stat_mp_q != '1)) stat_mp_d = stat_mp_q + STAT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_INIT;
      ghr_q     <= '0;
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else if (upd) begin
      cnt_q[bp.EX_pred_idx] <= cnt_d;
      ghr_q                 <= ghr_d;
      stat_br_q             <= stat_br_d;
      stat_mp_q             <= stat_mp_d;
    end
  end

  assign bp.ghr              = ghr_q;
  assign bp.stat_branches    = stat_br_q;
  assign bp.stat_mispredicts = stat_mp_q;
endmodule
